// File: rtl/arc4_pkg.sv
// arc4_pkg: definitions shared by the ARC4 datapath stages.
//   - ksa_state_t   : key-scheduling FSM state encoding
//   - S_DEPTH       : size of the S permutation memory
//   - KSA_KEY_BYTES : default number of secret-key bytes
//   - key_byte()    : selects one byte of a secret key (byte 0 = MSB)
// Optional feature macro: KSA_FUSED_INIT_EN adds the INIT state, which
// writes the identity permutation before key scheduling starts.
package arc4_pkg;

  localparam int S_DEPTH       = 256;
  localparam int KSA_KEY_BYTES = 3;
  // Widest key that key_byte() can select from.
  localparam int MAX_KEY_BYTES = 32;

  typedef enum logic [2:0] {
    IDLE,
    RD_I,
    CAP_I,
    RD_J,
    CAP_J,
    WR_I,
`ifdef KSA_FUSED_INIT_EN
    WR_J,
    INIT
`else
    WR_J
`endif
  } ksa_state_t;

  // The caller left-aligns its key in a MAX_KEY_BYTES-wide vector, so
  // byte 0 is always the top byte regardless of the real key length.
  function automatic logic [7:0] key_byte(
    input logic [8*MAX_KEY_BYTES-1:0] key,
    input int unsigned                idx
  );
    return key[8*(MAX_KEY_BYTES-1-idx) +: 8];
  endfunction

endpackage

// File: rtl/ksa.sv
// ksa: ARC4 key-scheduling stage.
// Permutes the 256-byte S memory with the secret key:
//   j = 0; for i in 0..255 { j += S[i] + key[i mod KEY_BYTES]; swap(S[i], S[j]) }
// Each iteration takes six cycles (read i, capture, read j, capture,
// write i, write j) on a single-port RAM with 1-cycle read latency.
//
// Ports:
//   clk       in  : clock, rising edge
//   rst_n     in  : synchronous active-low reset
//   en        in  : start request, honoured only while rdy=1
//   rdy       out : idle, ready to accept en
//   key       in  : secret key (8*KEY_BYTES bits, byte 0 = MSB), latched on accept
//   s_addr    out : S memory address
//   s_rddata  in  : S read data, valid the cycle after the address
//   s_wrdata  out : S write data
//   s_wren    out : S write enable
//
// Parameter: KEY_BYTES (1..MAX_KEY_BYTES), default 3.
// Macro KSA_FUSED_INIT_EN: when defined, an INIT phase first writes
// S[k]=k for k=0..255 (256 extra cycles); when undefined, S must already
// hold the identity permutation when en is asserted.
module ksa
  import arc4_pkg::*;
#(
  parameter int KEY_BYTES = KSA_KEY_BYTES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  output logic                   rdy,
  input  logic [8*KEY_BYTES-1:0] key,
  output logic [7:0]             s_addr,
  input  logic [7:0]             s_rddata,
  output logic [7:0]             s_wrdata,
  output logic                   s_wren
);

  localparam int         KIDX_W   = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int         KW       = 8 * MAX_KEY_BYTES;
  localparam logic [7:0] LAST_IDX = 8'(S_DEPTH - 1);
  localparam logic [KIDX_W-1:0] LAST_KIDX = KIDX_W'(KEY_BYTES - 1);

  ksa_state_t              state_reg, state_next;
  logic [7:0]              i_reg, i_next;
  logic [7:0]              j_reg, j_next;
  logic [KIDX_W-1:0]       kidx_reg, kidx_next;
  logic [7:0]              si_reg, si_next;
  logic [7:0]              sj_reg, sj_next;
  logic [8*KEY_BYTES-1:0]  key_reg, key_next;

  // Key bytes as a small array so the running key byte is a plain mux
  // on kidx rather than a modulo of i.
  logic [KW-1:0] key_wide;
  logic [7:0]    key_bytes [KEY_BYTES];
  logic [7:0]    cur_key_byte;

  assign key_wide = KW'(key_reg) << (KW - 8*KEY_BYTES);

  for (genvar gi = 0; gi < KEY_BYTES; gi++) begin : g_key_byte
    assign key_bytes[gi] = key_byte(key_wide, gi);
  end

  assign cur_key_byte = key_bytes[kidx_reg];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
      kidx_reg  <= '0;
      si_reg    <= '0;
      sj_reg    <= '0;
      key_reg   <= '0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
      kidx_reg  <= kidx_next;
      si_reg    <= si_next;
      sj_reg    <= sj_next;
      key_reg   <= key_next;
    end
  end

  // Next-state and outputs. Outputs depend only on state and registers,
  // never on en or s_rddata directly.
  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    kidx_next  = kidx_reg;
    si_next    = si_reg;
    sj_next    = sj_reg;
    key_next   = key_reg;
    rdy        = 1'b0;
    s_addr     = 8'd0;
    s_wrdata   = 8'd0;
    s_wren     = 1'b0;

    case (state_reg)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
          key_next  = key;
          i_next    = 8'd0;
          j_next    = 8'd0;
          kidx_next = '0;
`ifdef KSA_FUSED_INIT_EN
          state_next = INIT;
`else
          state_next = RD_I;
`endif
        end
      end

`ifdef KSA_FUSED_INIT_EN
      // i doubles as the fill counter; it wraps back to 0 on the final
      // write, which is exactly the starting index for key scheduling.
      INIT: begin
        s_addr   = i_reg;
        s_wrdata = i_reg;
        s_wren   = 1'b1;
        i_next   = i_reg + 8'd1;
        if (i_reg == LAST_IDX) begin
          state_next = RD_I;
        end
      end
`endif

      RD_I: begin
        s_addr     = i_reg;
        state_next = CAP_I;
      end

      CAP_I: begin
        si_next    = s_rddata;
        j_next     = j_reg + s_rddata + cur_key_byte;
        state_next = RD_J;
      end

      RD_J: begin
        s_addr     = j_reg;
        state_next = CAP_J;
      end

      CAP_J: begin
        sj_next    = s_rddata;
        state_next = WR_I;
      end

      WR_I: begin
        s_addr     = i_reg;
        s_wrdata   = sj_reg;
        s_wren     = 1'b1;
        state_next = WR_J;
      end

      // When i==j both writes hit the same address with the same value,
      // so the swap degenerates correctly without a special case.
      WR_J: begin
        s_addr    = j_reg;
        s_wrdata  = si_reg;
        s_wren    = 1'b1;
        i_next    = i_reg + 8'd1;
        kidx_next = (kidx_reg == LAST_KIDX) ? '0 : kidx_reg + 1'b1;
        state_next = (i_reg == LAST_IDX) ? IDLE : RD_I;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ksa.sv
// tb_ksa: self-checking bench for ksa with a behavioural single-port
// S RAM (1-cycle read latency) and an ARC4 key-schedule reference.
// Define KSA_FUSED_INIT_EN for both bench and RTL to test the INIT phase.
`timescale 1ns/1ps
module tb_ksa;

`ifdef KSA_FUSED_INIT_EN
  localparam int RUN_CYCLES  = 1792;
  localparam int INIT_WRITES = 256;
`else
  localparam int RUN_CYCLES  = 1536;
  localparam int INIT_WRITES = 0;
`endif
  localparam int WAIT_LIMIT = 4000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [23:0] key = 24'h0;
  logic        rdy;
  logic [7:0]  s_addr;
  logic [7:0]  s_rddata;
  logic [7:0]  s_wrdata;
  logic        s_wren;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem  [256];
  logic [7:0] gold [256];
  logic [7:0] wr_addr_q [$];
  logic [7:0] wr_data_q [$];

  ksa #(.KEY_BYTES(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .rdy      (rdy),
    .key      (key),
    .s_addr   (s_addr),
    .s_rddata (s_rddata),
    .s_wrdata (s_wrdata),
    .s_wren   (s_wren)
  );

  always #5 clk = ~clk;

  // Single-port RAM; the read captures the old contents, then any write
  // lands. Every write is also logged in order.
  always @(posedge clk) begin
    s_rddata = mem[s_addr];
    if (s_wren) begin
      mem[s_addr] = s_wrdata;
      wr_addr_q.push_back(s_addr);
      wr_data_q.push_back(s_wrdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_identity();
    for (int k = 0; k < 256; k++) mem[k] = 8'(k);
  endtask

  task automatic clear_log();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic gold_identity();
    for (int k = 0; k < 256; k++) gold[k] = 8'(k);
  endtask

  // Textbook ARC4 key schedule applied in place to gold[].
  task automatic gold_ksa(input logic [23:0] k);
    logic [7:0] j;
    logic [7:0] t;
    logic [7:0] kb;
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      kb = k[8*(2 - (i % 3)) +: 8];
      j = 8'(j + gold[i] + kb);
      t = gold[i];
      gold[i] = gold[j];
      gold[j] = t;
    end
  endtask

  // Accepting edge E0 happens inside; returns #1 after E0. The key input
  // is scrambled right afterwards, which the DUT must ignore.
  task automatic start_run(input logic [23:0] k);
    key = k;
    en  = 1'b1;
    tick();
    en  = 1'b0;
    key = ~k;
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (!rdy && n < WAIT_LIMIT) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    key   = 24'hABCDEF;
    tick();
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %b want 1", rdy); end
    checks++;
    if (s_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b want 0", s_wren); end
    checks++;
    if (s_addr !== 8'd0) begin errors++; $display("FAIL reset_addr got %h want 00", s_addr); end
    checks++;
    if (s_wrdata !== 8'd0) begin errors++; $display("FAIL reset_wrdata got %h want 00", s_wrdata); end
    rst_n = 1'b1;
    en    = 1'b0;
    clear_log();
    repeat (100) tick();
    checks++;
    if (wr_addr_q.size() !== 0) begin errors++; $display("FAIL idle_writes got %0d want 0", wr_addr_q.size()); end
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL idle_rdy got %b want 1", rdy); end
    $display("test_reset done");
  endtask

  task automatic test_key_010203();
    int n;
    load_identity();
    clear_log();
    start_run(24'h010203);
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL k010203_rdy_fall got %b want 0", rdy); end
    checks++;
    if (s_addr !== 8'd0) begin errors++; $display("FAIL k010203_first_addr got %h want 00", s_addr); end
    wait_rdy(n);
    checks++;
    if (n !== RUN_CYCLES) begin errors++; $display("FAIL k010203_latency got %0d want %0d", n, RUN_CYCLES); end
    checks++;
    if (wr_addr_q.size() < INIT_WRITES + 4) begin
      errors++; $display("FAIL k010203_nwrites got %0d want >= %0d", wr_addr_q.size(), INIT_WRITES + 4);
    end else begin
      // Iteration 0: j=1 -> S[0]=1, S[1]=0. Iteration 1: j=1+0+2=3 -> S[1]=3, S[3]=0.
      if ({wr_addr_q[INIT_WRITES], wr_data_q[INIT_WRITES]} !== {8'd0, 8'd1}) begin
        errors++; $display("FAIL k010203_w0 got S[%h]=%h want S[00]=01", wr_addr_q[INIT_WRITES], wr_data_q[INIT_WRITES]);
      end
      checks++;
      if ({wr_addr_q[INIT_WRITES+1], wr_data_q[INIT_WRITES+1]} !== {8'd1, 8'd0}) begin
        errors++; $display("FAIL k010203_w1 got S[%h]=%h want S[01]=00", wr_addr_q[INIT_WRITES+1], wr_data_q[INIT_WRITES+1]);
      end
      checks++;
      if ({wr_addr_q[INIT_WRITES+2], wr_data_q[INIT_WRITES+2]} !== {8'd1, 8'd3}) begin
        errors++; $display("FAIL k010203_w2 got S[%h]=%h want S[01]=03", wr_addr_q[INIT_WRITES+2], wr_data_q[INIT_WRITES+2]);
      end
      checks++;
      if ({wr_addr_q[INIT_WRITES+3], wr_data_q[INIT_WRITES+3]} !== {8'd3, 8'd0}) begin
        errors++; $display("FAIL k010203_w3 got S[%h]=%h want S[03]=00", wr_addr_q[INIT_WRITES+3], wr_data_q[INIT_WRITES+3]);
      end
    end
    gold_identity();
    gold_ksa(24'h010203);
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (mem[k] !== gold[k]) begin errors++; $display("FAIL k010203_final S[%0d] got %h want %h", k, mem[k], gold[k]); end
    end
    $display("test_key_010203 done latency=%0d", n);
  endtask

  task automatic test_key_zero();
    int n;
    load_identity();
    clear_log();
    start_run(24'h000000);
    wait_rdy(n);
    checks++;
    if (n !== RUN_CYCLES) begin errors++; $display("FAIL kzero_busy got %0d want %0d", n, RUN_CYCLES); end
    checks++;
    if (wr_addr_q.size() !== INIT_WRITES + 512) begin
      errors++; $display("FAIL kzero_nwrites got %0d want %0d", wr_addr_q.size(), INIT_WRITES + 512);
    end else begin
      // i=2: j = 1 + 2 + 0 = 3 -> S[2]=3, S[3]=2
      if ({wr_addr_q[INIT_WRITES+4], wr_data_q[INIT_WRITES+4]} !== {8'd2, 8'd3}) begin
        errors++; $display("FAIL kzero_w4 got S[%h]=%h want S[02]=03", wr_addr_q[INIT_WRITES+4], wr_data_q[INIT_WRITES+4]);
      end
      checks++;
      if ({wr_addr_q[INIT_WRITES+5], wr_data_q[INIT_WRITES+5]} !== {8'd3, 8'd2}) begin
        errors++; $display("FAIL kzero_w5 got S[%h]=%h want S[03]=02", wr_addr_q[INIT_WRITES+5], wr_data_q[INIT_WRITES+5]);
      end
    end
    $display("test_key_zero done busy=%0d", n);
  endtask

  task automatic test_full_run();
    int n;
    load_identity();
    start_run(24'h1E4600);
    wait_rdy(n);
    checks++;
    if (n !== RUN_CYCLES) begin errors++; $display("FAIL full_latency got %0d want %0d", n, RUN_CYCLES); end
    gold_identity();
    gold_ksa(24'h1E4600);
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (mem[k] !== gold[k]) begin errors++; $display("FAIL full_final S[%0d] got %h want %h", k, mem[k], gold[k]); end
    end
    $display("test_full_run done key=1e4600 latency=%0d", n);
  endtask

  task automatic test_reset_mid_run();
    int n;
    load_identity();
    start_run(24'h1E4600);
    repeat (699) tick();
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", rdy); end
    rst_n = 1'b0;
    tick();
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL midrst_rdy got %b want 1", rdy); end
    checks++;
    if (s_wren !== 1'b0) begin errors++; $display("FAIL midrst_wren got %b want 0", s_wren); end
    rst_n = 1'b1;
    load_identity();
    clear_log();
    start_run(24'h010203);
    checks++;
    if (s_addr !== 8'd0) begin errors++; $display("FAIL midrst_restart_addr got %h want 00", s_addr); end
    wait_rdy(n);
    checks++;
    if (n !== RUN_CYCLES) begin errors++; $display("FAIL midrst_latency got %0d want %0d", n, RUN_CYCLES); end
    checks++;
    if (wr_addr_q.size() < INIT_WRITES + 2) begin
      errors++; $display("FAIL midrst_nwrites got %0d want >= %0d", wr_addr_q.size(), INIT_WRITES + 2);
    end else if ({wr_addr_q[INIT_WRITES], wr_data_q[INIT_WRITES], wr_addr_q[INIT_WRITES+1], wr_data_q[INIT_WRITES+1]}
                 !== {8'd0, 8'd1, 8'd1, 8'd0}) begin
      errors++;
      $display("FAIL midrst_first_swap got S[%h]=%h,S[%h]=%h want S[00]=01,S[01]=00", wr_addr_q[INIT_WRITES],
               wr_data_q[INIT_WRITES], wr_addr_q[INIT_WRITES+1], wr_data_q[INIT_WRITES+1]);
    end
    $display("test_reset_mid_run done latency=%0d", n);
  endtask

  task automatic test_en_busy();
    int n;
    load_identity();
    start_run(24'h000000);
    n = 0;
    while (!rdy && n < WAIT_LIMIT) begin
      en = ((n % 97) == 13);
      tick();
      n++;
    end
    en = 1'b0;
    checks++;
    if (n !== RUN_CYCLES) begin errors++; $display("FAIL enbusy_latency got %0d want %0d", n, RUN_CYCLES); end
    gold_identity();
    gold_ksa(24'h000000);
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (mem[k] !== gold[k]) begin errors++; $display("FAIL enbusy_final S[%0d] got %h want %h", k, mem[k], gold[k]); end
    end
    $display("test_en_busy done latency=%0d", n);
  endtask

  task automatic test_back_to_back();
    int n;
    load_identity();
    start_run(24'h010203);
    wait_rdy(n);
    start_run(24'h000000);
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL b2b_start got rdy=%b want 0", rdy); end
    wait_rdy(n);
    checks++;
    if (n !== RUN_CYCLES) begin errors++; $display("FAIL b2b_latency got %0d want %0d", n, RUN_CYCLES); end
    gold_identity();
`ifndef KSA_FUSED_INIT_EN
    gold_ksa(24'h010203);
`endif
    gold_ksa(24'h000000);
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (mem[k] !== gold[k]) begin errors++; $display("FAIL b2b_final S[%0d] got %h want %h", k, mem[k], gold[k]); end
    end
    $display("test_back_to_back done latency=%0d", n);
  endtask

`ifdef KSA_FUSED_INIT_EN
  task automatic test_fused_init();
    int n;
    for (int k = 0; k < 256; k++) mem[k] = 8'(k) ^ 8'hA5;
    clear_log();
    start_run(24'h1E4600);
    wait_rdy(n);
    checks++;
    if (n !== 1792) begin errors++; $display("FAIL fused_latency got %0d want 1792", n); end
    checks++;
    if (wr_addr_q.size() !== 768) begin
      errors++; $display("FAIL fused_nwrites got %0d want 768", wr_addr_q.size());
    end else begin
      for (int k = 0; k < 256; k++) begin
        checks++;
        if ({wr_addr_q[k], wr_data_q[k]} !== {8'(k), 8'(k)}) begin
          errors++; $display("FAIL fused_init_w%0d got S[%h]=%h want S[%h]=%h", k, wr_addr_q[k], wr_data_q[k], 8'(k), 8'(k));
        end
      end
    end
    gold_identity();
    gold_ksa(24'h1E4600);
    for (int k = 0; k < 256; k++) begin
      checks++;
      if (mem[k] !== gold[k]) begin errors++; $display("FAIL fused_final S[%0d] got %h want %h", k, mem[k], gold[k]); end
    end
    $display("test_fused_init done latency=%0d", n);
  endtask
`endif

  initial begin
    test_reset();
    test_key_010203();
    test_key_zero();
    test_full_run();
    test_reset_mid_run();
    test_en_busy();
    test_back_to_back();
`ifdef KSA_FUSED_INIT_EN
    test_fused_init();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
